// File: rtl/vector_ram_arbiter.sv
// Two-requester arbiter for the vector RAM request port with read-response routing.
// Latency: zero on the request path (grant is combinational); responses pass straight through.
// Backpressure: rq_ready follows ram_ready; reads stall while the tag FIFO is full; responses cannot be stalled.
module vector_ram_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int PARALLELISM     = 4,
  parameter int LENGTH          = 32,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [1:0]                                   rq_valid,
  input  logic [1:0]                                   rq_write,
  input  logic [2*PARALLELISM*$clog2(LENGTH)-1:0]      rq_addr,
  input  logic [2*PARALLELISM*DATA_WIDTH-1:0]          rq_wdata,
  output logic [1:0]                                   rq_ready,
  output logic [1:0]                                   rsp_valid,
  output logic [PARALLELISM*DATA_WIDTH-1:0]            rsp_rdata,
  output logic                                         ram_valid,
  output logic                                         ram_write,
  output logic [PARALLELISM*$clog2(LENGTH)-1:0]        ram_addr,
  output logic [PARALLELISM*DATA_WIDTH-1:0]            ram_wdata,
  input  logic                                         ram_ready,
  input  logic                                         ram_rvalid,
  input  logic [PARALLELISM*DATA_WIDTH-1:0]            ram_rdata,
  output logic                                         err_unexpected
);
  localparam int ADDR_WIDTH = $clog2(LENGTH);
  localparam int AW = PARALLELISM * ADDR_WIDTH;
  localparam int DW = PARALLELISM * DATA_WIDTH;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tag_mem_q [MAX_OUTSTANDING];
  logic            tag_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            err_q, err_d;

  logic            tag_empty, tag_full, pop, push, head;
  logic [1:0]      eligible, cand, grant;
  logic            own, oth, pick, idle_pick;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Tag FIFO status; a same-cycle pop frees a slot for a read beat
  always_comb begin
    tag_empty = (occ_q == '0);
    tag_full  = (occ_q == OW'(MAX_OUTSTANDING));
    head      = tag_mem_q[rd_ptr_q];
    pop       = ram_rvalid & ~tag_empty;
    eligible  = rq_write | {2{~tag_full | pop}};
    cand      = rq_valid & eligible;
  end

  // Ownership FSM: burst-bounded round robin, an ineligible owner lends the slot to the other side
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    grant     = 2'b00;
    idle_pick = 1'b0;
    pick      = 1'b0;
    own       = (state_q == OWN1);
    oth       = ~own;
    case (state_q)
      IDLE: idle_pick = 1'b1;
      OWN0, OWN1: begin
        if (!rq_valid[own]) begin
          // Owner went quiet: fall through to the IDLE decision this same cycle
          state_d   = IDLE;
          rr_d      = oth;
          idle_pick = 1'b1;
        end else if (cnt_q == CW'(MAX_BURST)) begin
          cnt_d = '0;
          if (rq_valid[oth]) begin
            state_d = own ? OWN0 : OWN1;
            rr_d    = oth;
          end
        end else if (cand[own]) begin
          grant[own] = 1'b1;
          if (ram_ready) cnt_d = cnt_q + 1'b1;
        end else if (cand[oth]) begin
          grant[oth] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (idle_pick && (cand != 2'b00)) begin
      pick        = (cand == 2'b11) ? rr_d : cand[1];
      grant[pick] = 1'b1;
      if (ram_ready) begin
        state_d = pick ? OWN1 : OWN0;
        cnt_d   = CW'(1);
      end
    end
  end

  // Request-path mux and response routing, all forced idle while reset is held
  always_comb begin
    rq_ready       = rst ? 2'b00 : (grant & eligible & {2{ram_ready}});
    ram_valid      = |(rq_valid & rq_ready);
    ram_write      = grant[1] ? rq_write[1] : rq_write[0];
    ram_addr       = grant[1] ? rq_addr[2*AW-1:AW] : rq_addr[AW-1:0];
    ram_wdata      = grant[1] ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
    push           = ram_valid & ~ram_write;
    rsp_valid      = rst ? 2'b00 : {pop & head, pop & ~head};
    rsp_rdata      = ram_rdata;
    err_unexpected = err_q;
  end

  // Tag FIFO next state and sticky unexpected-response flag
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    err_d     = err_q | (ram_rvalid & tag_empty);
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant[1];
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
      tag_mem_q <= tag_mem_d;
    end
  end
endmodule
